mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the instruction-fetch stage (I port) and the memory-access stage (D port).
- Sequences each access over a fixed multi-cycle memory latency.
- Returns registered read data and a one-cycle acknowledge to the requester that was served.
- Produces per-port stall signals so the pipeline freezes while an access is outstanding.

Parameters:
LAT  2   memory access cycles per transaction (legal 1..15)
AW   16  address width
DW   16  data width

Ports:
clk        in   1   clock, all logic on rising edge
rst        in   1   synchronous reset, active-high
i_req      in   1   instruction read request, level, held until i_ack
i_addr     in   AW  instruction address (pc)
i_rdata    out  DW  fetched instruction, registered
i_ack      out  1   one-cycle pulse, i_rdata valid
d_re       in   1   data read request, level, held until d_ack
d_we       in   1   data write request, level, held until d_ack
d_addr     in   AW  data address
d_wdata    in   DW  write data
d_rdata    out  DW  load data, registered
d_ack      out  1   one-cycle pulse, D access complete
mem_re     out  1   memory read enable
mem_we     out  1   memory write enable
mem_addr   out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in   DW  memory read data, valid in final access cycle
stall_if   out  1   i_req & ~i_ack (combinational)
stall_mem  out  1   (d_re|d_we) & ~d_ack (combinational)
busy       out  1   state != IDLE

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D, ACK_I, ACK_D. Reset -> IDLE.
- Reset values: all registered outputs 0, cnt=0, last_d=0.
- IDLE arbitration, sampled each cycle:
  - only D pending (d_re|d_we) -> BUSY_D
  - only i_req -> BUSY_I
  - both pending -> BUSY_D if last_d=0, else BUSY_I
  - none pending -> stay in IDLE
- On grant edge:
  - latch addr, wdata and the op type (write if d_we=1, else read) into internal regs
  - cnt <= LAT-1
  - last_d <= 1 for a D grant, 0 for an I grant
- BUSY_x:
  - mem_addr/mem_wdata driven from the latched regs; stable for all LAT cycles
  - mem_re=1 (read) or mem_we=1 (write) for exactly LAT consecutive cycles
  - cnt decrements each cycle
  - when cnt==0: capture mem_rdata into the port's rdata reg (reads only), go to ACK_x
- ACK_x: x_ack=1 for exactly one cycle; mem_re=mem_we=0; next state IDLE.
- Latency: request seen in IDLE at cycle N -> mem enable cycles N+1..N+LAT -> ack in cycle N+LAT+1. The next grant can occur no earlier than N+LAT+2.
- d_re and d_we both high: treated as a write. d_rdata <= 0 on its ack.
- Write ack: d_rdata <= 0. i_rdata and d_rdata otherwise hold until the next read ack on that port.
- Requests are not re-sampled while in BUSY/ACK. Address/data changes mid-access have no effect.
- A request dropped before ack (protocol violation) does not abort the access; the ack is still issued.
- Fairness: with both ports continuously requesting, grants alternate D, I, D, I ... No port waits more than one other transaction.
- mem_* outputs are 0 in IDLE and ACK (mem_addr/mem_wdata 0 in IDLE).
- Reset mid-operation: at the edge with rst=1, go to IDLE. mem_re/mem_we are 0 from the next cycle. No ack is issued for the aborted access. A partially performed write is not retried.

Test Plan:
- LAT=2. i_req=1, i_addr=0x0010, memory returns 0xABCD at cycle 0 -> mem_re=1, mem_addr=0x0010 in cycles 1-2; i_ack=1 in cycle 3 with i_rdata=0xABCD; stall_if high in cycles 0-2, low in cycle 3.
- LAT=2. d_we=1, d_addr=0x0020, d_wdata=0x1234 -> mem_we=1 in cycles 1-2 with addr/data stable; d_ack in cycle 3; d_rdata=0; a subsequent read of 0x0020 returns 0x1234.
- i_req and d_re asserted together and held, refilled after each ack -> grant order D, I, D, I. Each ack is exactly one cycle. mem_re and mem_we are never both high.
- d_re=d_we=1, addr 0x0030, data 0x5555 -> write performed (mem_we high, mem_re low); d_ack with d_rdata=0.
- rst pulsed in the second BUSY_D cycle of a read -> IDLE on that edge; no d_ack; mem_re=0 the following cycle; all outputs at reset values.
- LAT=1. Back-to-back I reads at 0x0000 and 0x0001 -> each fetch is 3 cycles (grant, 1 mem cycle, ack); i_ack pulses in cycles 2 and 5.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline I/D ports, the arbiter and the unified memory.
// The arbiter takes the slave view; the pipeline and memory side takes master.
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_re;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall_if;
    logic          stall_mem;
    logic          busy;

    modport slave (
        input  i_req, i_addr, d_re, d_we, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_ack, d_rdata, d_ack,
        output mem_re, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_mem, busy
    );

    modport master (
        output i_req, i_addr, d_re, d_we, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack,
        input  mem_re, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_mem, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter for a single-ported unified memory.
// Fixed LAT-cycle accesses, alternating priority when both ports contend.
module mem_arbiter #(
    parameter int LAT = 2,
    parameter int AW  = 16,
    parameter int DW  = 16
) (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, BUSY_I, BUSY_D, ACK_I, ACK_D
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t        state;
    state_t        state_nx;
    logic [3:0]    cnt;
    logic          last_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          we_q;
    logic [DW-1:0] i_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          grant_i;
    logic          grant_d;
    logic          d_pend;
    logic          in_busy;

    assign d_pend  = bus.d_re | bus.d_we;
    assign in_busy = (state == BUSY_I) | (state == BUSY_D);

    always_comb begin
        state_nx = state;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        unique case (state)
            IDLE: begin
                // D wins a tie unless it was served last
                if (d_pend && (!bus.i_req || !last_d)) begin
                    state_nx = BUSY_D;
                    grant_d  = 1'b1;
                end else if (bus.i_req) begin
                    state_nx = BUSY_I;
                    grant_i  = 1'b1;
                end
            end
            BUSY_I:  if (cnt == 4'd0) state_nx = ACK_I;
            BUSY_D:  if (cnt == 4'd0) state_nx = ACK_D;
            ACK_I:   state_nx = IDLE;
            ACK_D:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            last_d    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (grant_i || grant_d) begin
                addr_q  <= grant_d ? bus.d_addr : bus.i_addr;
                wdata_q <= grant_d ? bus.d_wdata : '0;
                we_q    <= grant_d & bus.d_we;
                cnt     <= CNT_INIT;
                last_d  <= grant_d;
            end else if (in_busy && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == BUSY_I && cnt == 4'd0)
                i_rdata_q <= bus.mem_rdata;
            // a completed write clears the load data register
            if (state == BUSY_D && cnt == 4'd0)
                d_rdata_q <= we_q ? '0 : bus.mem_rdata;
        end
    end

    assign bus.mem_re    = in_busy & ~we_q;
    assign bus.mem_we    = in_busy & we_q;
    assign bus.mem_addr  = in_busy ? addr_q : '0;
    assign bus.mem_wdata = in_busy ? wdata_q : '0;
    assign bus.i_ack     = (state == ACK_I);
    assign bus.d_ack     = (state == ACK_D);
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state != IDLE);
    assign bus.stall_if  = bus.i_req & ~bus.i_ack;
    assign bus.stall_mem = d_pend & ~bus.d_ack;
endmodule
